// File: rtl/alu_prog_pkg.sv
// alu_prog_pkg: opcodes, flag bit positions and FSM encoding shared by the ALU program runner
package alu_prog_pkg;
  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_SAR  = 3'd7;
  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_V = 2;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_OUT, S_DONE} state_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU (a op b) -> result, flags {V,N,Z}; optional ADD/SUB saturation
module alu_core
  import alu_prog_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit SAT   = 1'b0
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic [2:0]       flags_o
);
  localparam int SW = $clog2(WIDTH);
  logic [WIDTH-1:0] sum, diff, raw, sat_val;
  logic [SW-1:0] sh;
  logic v_add, v_sub, v;
  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;
  assign sh   = b_i[SW-1:0];
  assign v_add = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
  assign v_sub = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
  // On overflow the true result always has the sign of a
  assign sat_val = a_i[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  always_comb begin
    raw = a_i;
    case (op_i)
      OP_LOAD: raw = b_i;
      OP_ADD:  raw = sum;
      OP_SUB:  raw = diff;
      OP_AND:  raw = a_i & b_i;
      OP_OR:   raw = a_i | b_i;
      OP_XOR:  raw = a_i ^ b_i;
      OP_SHL:  raw = a_i << sh;
      OP_SAR:  raw = $signed(a_i) >>> sh;
      default: raw = a_i;
    endcase
  end
  assign v = (op_i == OP_ADD) ? v_add : (op_i == OP_SUB) ? v_sub : 1'b0;
  assign result_o = (SAT && v) ? sat_val : raw;
  assign flags_o[FLG_V] = v;
  assign flags_o[FLG_N] = result_o[WIDTH-1];
  assign flags_o[FLG_Z] = result_o == '0;
endmodule

// File: rtl/alu_program_runner.sv
// alu_program_runner: runs a loaded ALU program on an accumulator, streaming each result with flags over valid/ready
module alu_program_runner
  import alu_prog_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter bit SAT   = 1'b0,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [2:0]       prog_op,
  input  logic [WIDTH-1:0] prog_operand,
  input  logic [AW:0]      prog_len,
  input  logic             start,
  input  logic             abort,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [2:0]       data_type,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);
  state_t state_q;
  logic [AW-1:0] pc_q;
  logic [AW:0] len_q;
  logic [WIDTH-1:0] acc_q, acc_d, data_out_q;
  logic [2:0] type_q, flags_d;
  logic out_valid_q, done_q;
  logic [2:0] mem_op [DEPTH];
  logic [WIDTH-1:0] mem_opnd [DEPTH];
  alu_core #(.WIDTH(WIDTH), .SAT(SAT)) u_alu (
    .a_i(acc_q), .b_i(mem_opnd[pc_q]), .op_i(mem_op[pc_q]), .result_o(acc_d), .flags_o(flags_d)
  );
  // Program memory survives rst; writes only land while idle
  always_ff @(posedge clk)
    if (prog_we && state_q == S_IDLE) begin
      mem_op[prog_addr]   <= prog_op;
      mem_opnd[prog_addr] <= prog_operand;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      len_q       <= '0;
      acc_q       <= '0;
      data_out_q  <= '0;
      type_q      <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else if (abort) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= state_q == S_DONE;
      case (state_q)
        S_IDLE:
          if (start && prog_len == '0) state_q <= S_DONE;
          else if (start) begin
            acc_q   <= '0;
            pc_q    <= '0;
            len_q   <= prog_len;
            state_q <= S_EXEC;
          end
        S_EXEC: begin
          acc_q       <= acc_d;
          data_out_q  <= acc_d;
          type_q      <= flags_d;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT:
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if ({1'b0, pc_q} == len_q - (AW+1)'(1)) state_q <= S_DONE;
            else begin
              pc_q    <= pc_q + AW'(1);
              state_q <= S_EXEC;
            end
          end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  assign data_out  = data_out_q;
  assign data_type = type_q;
  assign out_valid = out_valid_q;
  assign busy      = state_q != S_IDLE;
  assign done      = done_q;
endmodule
